// File: rtl/serial_adder.sv
// Bit-serial adder: computes a + b + cin one bit per cycle, LSB first, under a start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [WIDTH-1:0]   sa_reg;
    logic [WIDTH-1:0]   sb_reg;
    logic [WIDTH-1:0]   ss_reg;
    logic               carry_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic               cout_reg;

    logic               s_bit;
    logic               carry_next;
    logic               last_bit;
    logic               load;

    always_comb begin
        state_next = state_reg;
        s_bit      = sa_reg[0] ^ sb_reg[0] ^ carry_reg;
        carry_next = (sa_reg[0] & sb_reg[0]) | (sa_reg[0] & carry_reg) | (sb_reg[0] & carry_reg);
        last_bit   = (state_reg == RUN) && (cnt_reg == LAST_BIT);
        // start is only honoured outside RUN, so operands in flight are never disturbed
        load       = start && (state_reg != RUN);
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            sa_reg    <= '0;
            sb_reg    <= '0;
            ss_reg    <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next == RUN);
            done_reg  <= (state_next == DONE);
            if (load) begin
                sa_reg    <= a;
                sb_reg    <= b;
                carry_reg <= cin;
                cnt_reg   <= '0;
            end else if (state_reg == RUN) begin
                sa_reg    <= sa_reg >> 1;
                sb_reg    <= sb_reg >> 1;
                carry_reg <= carry_next;
                ss_reg    <= {s_bit, ss_reg[WIDTH-1:1]};
                // hold the counter on the final bit so it never wraps
                if (!last_bit) cnt_reg <= cnt_reg + CNT_W'(1);
                if (last_bit) begin
                    sum_reg  <= {s_bit, ss_reg[WIDTH-1:1]};
                    cout_reg <= carry_next;
                end
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_reg;

    // carry_reg holds the carry entering the MSB while the last bit is processed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (last_bit) begin
            ovf_reg <= carry_reg ^ carry_next;
        end
    end

    assign ovf = ovf_reg;
`endif

    assign busy = busy_reg;
    assign done = done_reg;
    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule
